// File: rtl/uart_cmd_sequencer.sv
// Assembles UART bytes into {opcode, data_hi, data_lo} commands with an inter-byte timeout.
// Optional CMD_CHKSUM_EN adds a trailing two's-complement checksum byte and a chk_err pulse.
module uart_cmd_sequencer #(
    parameter int TMO_CYCLES = 100000,
    parameter int TMO_W      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_ovr,
    output logic        tmo_err
`ifdef CMD_CHKSUM_EN
    ,
    output logic        chk_err
`endif
);

    // state | meaning
    // IDLE  | waiting for opcode byte
    // BYTE2 | opcode held, waiting for data_hi
    // BYTE3 | data_hi held, waiting for data_lo
    // CHK   | data_lo held, waiting for checksum (CMD_CHKSUM_EN only)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE2 = 2'd1,
        BYTE3 = 2'd2
`ifdef CMD_CHKSUM_EN
        ,
        CHK   = 2'd3
`endif
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, data_hi_q, frame_lo;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              accept, tmo_expire, tmo_hit, complete;

`ifdef CMD_CHKSUM_EN
    logic [7:0]        data_lo_q, chk_sum, chk_exp;
    logic              chk_bad;

    assign chk_sum  = opcode_q + data_hi_q + data_lo_q;
    assign chk_exp  = 8'h00 - chk_sum;
    assign frame_lo = data_lo_q;
`else
    assign frame_lo = rx_data;
`endif

    // clr_rx_rdy masks the cycle where the receiver still shows the acknowledged byte
    assign accept     = rx_rdy && !clr_rx_rdy;
    assign tmo_expire = (tmo_cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        tmo_hit  = 1'b0;
`ifdef CMD_CHKSUM_EN
        chk_bad  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) state_d = BYTE2;
            end
            BYTE2: begin
                if (accept) begin
                    state_d = BYTE3;
                end else if (tmo_expire) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            BYTE3: begin
                if (accept) begin
`ifdef CMD_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d  = IDLE;
                    complete = 1'b1;
`endif
                end else if (tmo_expire) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end
            end
`ifdef CMD_CHKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = IDLE;
                    if (rx_data == chk_exp) complete = 1'b1;
                    else                    chk_bad  = 1'b1;
                end else if (tmo_expire) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= TMO_LOAD;
            clr_rx_rdy <= 1'b0;
            cmd_rdy    <= 1'b0;
            cmd        <= 8'h00;
            data       <= 16'h0000;
            cmd_ovr    <= 1'b0;
            tmo_err    <= 1'b0;
            opcode_q   <= 8'h00;
            data_hi_q  <= 8'h00;
`ifdef CMD_CHKSUM_EN
            data_lo_q  <= 8'h00;
            chk_err    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clr_rx_rdy <= accept;
            tmo_err    <= tmo_hit;

            // down-counter reloads on every byte; zero is the last permitted idle cycle
            if (accept || state_q == IDLE || tmo_hit) tmo_cnt_q <= TMO_LOAD;
            else                                       tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);

            if (accept) begin
                case (state_q)
                    IDLE:  opcode_q  <= rx_data;
                    BYTE2: data_hi_q <= rx_data;
`ifdef CMD_CHKSUM_EN
                    BYTE3: data_lo_q <= rx_data;
`endif
                    default: ;
                endcase
            end

            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                cmd_ovr <= 1'b0;
            end
            if (complete) begin
                cmd     <= opcode_q;
                data    <= {data_hi_q, frame_lo};
                cmd_rdy <= 1'b1;
                if (cmd_rdy && !clr_cmd_rdy) cmd_ovr <= 1'b1;
            end
`ifdef CMD_CHKSUM_EN
            chk_err <= chk_bad;
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: framing, handshake guard, timeout, overrun, reset.
// Builds with or without CMD_CHKSUM_EN; frames get a checksum byte when it is defined.
module tb_uart_cmd_sequencer;

    localparam int TMO = 20;
    localparam int TW  = 5;
`ifdef CMD_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst, rx_rdy, clr_rx_rdy, cmd_rdy, clr_cmd_rdy, cmd_ovr, tmo_err;
    logic [7:0]  rx_data, cmd;
    logic [15:0] data;
`ifdef CMD_CHKSUM_EN
    logic        chk_err;
    int          chk_cnt = 0;
`endif

    int n_checks = 0, n_err = 0;
    int clr_cnt = 0, dbl_clr = 0, tmo_pulses = 0;
    int c0, t0;
    bit clr_prev = 1'b0;
    bit hold_extra = 1'b0;

    uart_cmd_sequencer #(.TMO_CYCLES(TMO), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .cmd(cmd), .data(data), .cmd_ovr(cmd_ovr), .tmo_err(tmo_err)
`ifdef CMD_CHKSUM_EN
        , .chk_err(chk_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_rx_rdy === 1'b1) begin
            clr_cnt++;
            if (clr_prev) dbl_clr++;
        end
        clr_prev = (clr_rx_rdy === 1'b1);
        if (tmo_err === 1'b1) tmo_pulses++;
`ifdef CMD_CHKSUM_EN
        if (chk_err === 1'b1) chk_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] csum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] s;
        s = a + b + c;
        return 8'h00 - s;
    endfunction

    // receiver model: hold rdy until acknowledged, optionally one extra cycle
    task automatic send_byte(input logic [7:0] b);
        int i;
        rx_data = b;
        rx_rdy  = 1'b1;
        i = 0;
        do begin
            tick;
            i++;
        end while (clr_rx_rdy !== 1'b1 && i < 8);
        if (clr_rx_rdy !== 1'b1) check("rx_ack_wait", {31'd0, clr_rx_rdy}, 32'd1);
        if (hold_extra) tick;
        rx_rdy = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                            input bit coincide);
        logic [7:0] last;
        send_byte(op);
        send_byte(hi);
`ifdef CMD_CHKSUM_EN
        send_byte(lo);
        last = csum(op, hi, lo);
`else
        last = lo;
`endif
        if (coincide) begin
            tick;
            clr_cmd_rdy = 1'b1;
        end
        send_byte(last);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic clear_cmd;
        clr_cmd_rdy = 1'b1;
        tick;
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        tick; tick;
        check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        check("rst_cmd_rdy",    {31'd0, cmd_rdy},    32'd0);
        check("rst_cmd",        {24'd0, cmd},        32'h00);
        check("rst_data",       {16'd0, data},       32'h0000);
        check("rst_cmd_ovr",    {31'd0, cmd_ovr},    32'd0);
        check("rst_tmo_err",    {31'd0, tmo_err},    32'd0);
        rst = 1'b0;

        // basic frame, rdy dropped as soon as acknowledged
        c0 = clr_cnt;
        send_byte(8'h05);
        send_byte(8'hAB);
`ifdef CMD_CHKSUM_EN
        send_byte(8'hCD);
        check("f1_rdy_before", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h83);
`else
        check("f1_rdy_before", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'hCD);
`endif
        check("f1_rdy",  {31'd0, cmd_rdy}, 32'd1);
        check("f1_cmd",  {24'd0, cmd},     32'h05);
        check("f1_data", {16'd0, data},    32'hABCD);
        check("f1_ovr",  {31'd0, cmd_ovr}, 32'd0);
        tick;
        check("f1_ack_pulses", clr_cnt - c0, NB);
        clear_cmd;
        check("f1_cleared", {31'd0, cmd_rdy}, 32'd0);

        // receiver holds rdy one cycle past the acknowledge
        hold_extra = 1'b1;
        c0 = clr_cnt;
        send_cmd(8'h3C, 8'h5A, 8'hA5, 1'b0);
        tick;
        hold_extra = 1'b0;
        check("f2_cmd",        {24'd0, cmd},  32'h3C);
        check("f2_data",       {16'd0, data}, 32'h5AA5);
        check("f2_ack_pulses", clr_cnt - c0,  NB);
        check("f2_no_double",  dbl_clr,       0);
        clear_cmd;

        // inter-byte timeout after a lone opcode
        t0 = tmo_pulses;
        send_byte(8'h11);
        repeat (TMO - 1) tick;
        check("tmo_not_early", {31'd0, tmo_err}, 32'd0);
        tick;
        check("tmo_fire",      {31'd0, tmo_err}, 32'd1);
        tick;
        check("tmo_one_cycle", {31'd0, tmo_err}, 32'd0);
        check("tmo_pulses",    tmo_pulses - t0,  1);
        check("tmo_no_cmd",    {31'd0, cmd_rdy}, 32'd0);
        send_cmd(8'h22, 8'h00, 8'h01, 1'b0);
        check("post_tmo_cmd",  {24'd0, cmd},  32'h22);
        check("post_tmo_data", {16'd0, data}, 32'h0001);
        clear_cmd;

        // byte arriving on the terminal-count cycle beats the timeout
        send_byte(8'h33);
        repeat (TMO - 1) tick;
        rx_data = 8'h44;
        rx_rdy  = 1'b1;
        tick;
        rx_rdy  = 1'b0;
        check("tc_accept", {31'd0, clr_rx_rdy}, 32'd1);
        check("tc_no_tmo", {31'd0, tmo_err},    32'd0);
        send_byte(8'h55);
`ifdef CMD_CHKSUM_EN
        send_byte(csum(8'h33, 8'h44, 8'h55));
`endif
        check("tc_cmd",  {24'd0, cmd},  32'h33);
        check("tc_data", {16'd0, data}, 32'h4455);
        clear_cmd;

        // overrun and clear
        send_cmd(8'h01, 8'h02, 8'h03, 1'b0);
        check("ovr_first", {31'd0, cmd_ovr}, 32'd0);
        send_cmd(8'h0A, 8'hBC, 8'hDE, 1'b0);
        check("ovr_set",  {31'd0, cmd_ovr}, 32'd1);
        check("ovr_rdy",  {31'd0, cmd_rdy}, 32'd1);
        check("ovr_cmd",  {24'd0, cmd},     32'h0A);
        check("ovr_data", {16'd0, data},    32'hBCDE);
        clear_cmd;
        check("clr_rdy",  {31'd0, cmd_rdy}, 32'd0);
        check("clr_ovr",  {31'd0, cmd_ovr}, 32'd0);
        check("clr_hold", {8'd0, cmd, data}, 32'h0ABCDE);

        // completion on the same edge as the consumer clear
        send_cmd(8'h61, 8'h62, 8'h63, 1'b0);
        send_cmd(8'h71, 8'h72, 8'h73, 1'b0);
        check("ovr_again", {31'd0, cmd_ovr}, 32'd1);
        send_cmd(8'h81, 8'h82, 8'h83, 1'b1);
        check("coin_rdy",  {31'd0, cmd_rdy}, 32'd1);
        check("coin_ovr",  {31'd0, cmd_ovr}, 32'd0);
        check("coin_cmd",  {24'd0, cmd},     32'h81);
        check("coin_data", {16'd0, data},    32'h8283);

        // reset in the middle of a frame
        send_byte(8'h77);
        send_byte(8'h88);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mrst_rdy",  {31'd0, cmd_rdy},    32'd0);
        check("mrst_cmd",  {24'd0, cmd},        32'h00);
        check("mrst_data", {16'd0, data},       32'h0000);
        check("mrst_ovr",  {31'd0, cmd_ovr},    32'd0);
        check("mrst_ack",  {31'd0, clr_rx_rdy}, 32'd0);
        send_cmd(8'h99, 8'h12, 8'h34, 1'b0);
        check("mrst_next_cmd",  {24'd0, cmd},     32'h99);
        check("mrst_next_data", {16'd0, data},    32'h1234);
        check("mrst_next_rdy",  {31'd0, cmd_rdy}, 32'd1);

`ifdef CMD_CHKSUM_EN
        clear_cmd;
        send_byte(8'h06); send_byte(8'h11); send_byte(8'h22); send_byte(8'hC7);
        check("chk_good_rdy",  {31'd0, cmd_rdy}, 32'd1);
        check("chk_good_data", {16'd0, data},    32'h1122);
        clear_cmd;
        c0 = chk_cnt;
        send_byte(8'h05); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h84);
        tick;
        check("chk_bad_pulse", chk_cnt - c0,      1);
        check("chk_bad_rdy",   {31'd0, cmd_rdy},  32'd0);
        check("chk_bad_hold",  {8'd0, cmd, data}, 32'h061122);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
